mem_1r1w_masked_param: RTL and testbench
========================================

Name: mem_1r1w_masked_param

Overview:
- Parametrised successor to the fixed-size masked 1R1W memory wrappers: a behavioural, single-clock simple-dual-port RAM.
- Generic depth, width and mask granularity.
- Configurable read latency with a valid pipeline.
- Automatic post-reset zero-initialisation sweep.
- Defined handling of out-of-range addresses and same-address read/write collisions.
- Drop-in target for generated memory configs where no vendor macro is used (simulation, ASIC behavioural, small FPGA LUTRAM).

Parameters:
DEPTH, 48, number of words; need not be a power of two (>=2)
WIDTH, 64, data bits per word
MASK_GRAN, 8, bits per write-mask lane; WIDTH must be a multiple of MASK_GRAN
READ_LATENCY, 1, cycles from read request to R0_valid; legal 1..4
Derived: ADDR_W = clog2(DEPTH); MASK_W = WIDTH/MASK_GRAN

Ports:
clk  input  1  single clock for both ports, rising edge
rst_n  input  1  asynchronous active-low reset
R0_addr  input  ADDR_W  read address
R0_en  input  1  read request
R0_data  output  WIDTH  read data
R0_valid  output  1  R0_data carries a new read result this cycle
W0_addr  input  ADDR_W  write address
W0_en  input  1  write request
W0_data  input  WIDTH  write data
W0_mask  input  MASK_W  lane enables; bit i covers W0_data[i*MASK_GRAN +: MASK_GRAN]
init_done  output  1  memory cleared, ports accepted

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, immediate):
  - R0_data=0, R0_valid=0, init_done=0.
  - Read pipeline flushed; FSM -> INIT; clear counter=0.
  - Array contents are not reset directly.
- FSM INIT:
  - Each rising edge writes all-zero to entry clr_cnt, then clr_cnt++.
  - When clr_cnt==DEPTH-1 is written, the next state is RUN.
  - Edges 1..DEPTH after rst_n release clear entries 0..DEPTH-1; init_done=1 from edge DEPTH onward.
  - R0_en/W0_en are ignored in INIT: no write, no R0_valid.
- FSM RUN: terminal until reset. init_done=1.
- Write (RUN, W0_en=1, W0_addr<DEPTH):
  - At the edge, lane i of mem[W0_addr] takes W0_data lane i iff W0_mask[i].
  - Other lanes keep their value.
  - W0_mask=0 is a legal no-op.
- Read (RUN, R0_en=1):
  - Request sampled at edge k; R0_valid=1 and R0_data=result after edge k+READ_LATENCY-1, for exactly one cycle per request.
  - READ_LATENCY=1 matches standard sdpram timing.
  - Extra latency stages are plain registers; the pipeline always advances, with no stall.
  - Back-to-back reads give one result per cycle, in order.
  - R0_data holds the last result while R0_valid=0.
- Out of range (addr >= DEPTH; only possible when DEPTH is not a power of two):
  - Write is dropped.
  - Read completes normally with R0_valid=1 and R0_data=0.
- Collision (same edge, R0_en & W0_en, R0_addr==W0_addr, in range): behaviour set by the optional feature below.
- Different-address simultaneous read/write: independent; read returns the pre-edge contents of its own address.
- Reset mid-read: in-flight results are discarded; no R0_valid for them after reset release.
- Reset mid-INIT: the sweep restarts at entry 0.

Optional Feature:
- Macro: MEM_1R1W_MASKED_FWD_EN.
- Defined (write-first forwarding): a collision returns the merged word. Lanes with W0_mask set take the new W0_data lanes; unmasked lanes take the old contents.
- Undefined (read-first): a collision returns the old contents of the entry. The write still commits at the same edge.
- Either way, array state after the edge is identical.
- Forwarding applies only to the same-edge collision. A read one cycle after a write always sees the new data, independent of READ_LATENCY.

Test Plan:
- Init sweep: DEPTH=48, release rst_n -> init_done=0 for edges 1..47, init_done=1 after edge 48; reads to all 48 addresses then return 0; R0_en/W0_en pulsed during INIT -> no R0_valid and contents stay 0.
- Masked write: write addr 5 data 0x1122334455667788 mask 0xFF, then data 0xAAAAAAAAAAAAAAAA mask 0x0F -> read addr 5 returns 0x11223344AAAAAAAA.
- Latency/throughput: READ_LATENCY=3, reads to addrs 0,1,2 on consecutive edges -> R0_valid high for 3 consecutive cycles starting 2 cycles after the first request edge, data in request order; R0_data held afterwards.
- Collision: mem[7]=0x0, same edge write addr 7 data all-ones mask 0x03 and read addr 7 -> with MEM_1R1W_MASKED_FWD_EN: 0x000000000000FFFF; without: 0x0; both builds: a subsequent read returns 0x000000000000FFFF.
- Out of range: DEPTH=48, write addr 50 data 0x1234 mask 0xFF then read addr 50 -> R0_valid=1, R0_data=0; entries 0..47 unchanged.
- Async reset mid-operation: assert rst_n=0 between edges with 2 reads in flight (READ_LATENCY=2) -> R0_valid/R0_data/init_done drop to 0 immediately; after release, no stale R0_valid; the sweep reruns and mem[5] reads 0.

Source files
------------

// File: rtl/mem_1r1w_masked_param.sv
// mem_1r1w_masked_param
// Behavioural single-clock simple-dual-port RAM (one read port, one write port)
// with per-lane write mask. After reset it zeroes the array one entry per cycle
// and only then accepts requests. Read results come out through a READ_LATENCY
// deep valid pipeline. Out-of-range writes are dropped and out-of-range reads
// return zero.
// Optional build macro MEM_1R1W_MASKED_FWD_EN: when defined, a read that hits
// the address being written on the same edge returns the merged (write-first)
// word. Otherwise the read returns the old contents (read-first).
module mem_1r1w_masked_param #(
    parameter int DEPTH        = 48,
    parameter int WIDTH        = 64,
    parameter int MASK_GRAN    = 8,
    parameter int READ_LATENCY = 1,
    localparam int ADDR_W      = $clog2(DEPTH),
    localparam int MASK_W      = WIDTH / MASK_GRAN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] R0_addr,
    input  logic              R0_en,
    output logic [WIDTH-1:0]  R0_data,
    output logic              R0_valid,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic              W0_en,
    input  logic [WIDTH-1:0]  W0_data,
    input  logic [MASK_W-1:0] W0_mask,
    output logic              init_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              run;
    logic              rd_in_range;
    logic              wr_in_range;
    logic              rd_req;
    logic              wr_req;
    logic [ADDR_W-1:0] rd_idx;
    logic [WIDTH-1:0]  rd_word;

    logic              vld_q [READ_LATENCY];
    logic [WIDTH-1:0]  dat_q [READ_LATENCY];

    assign run         = (state_q == ST_RUN);
    assign init_done   = run;
    assign rd_in_range = ({1'b0, R0_addr} < DEPTH_EXT);
    assign wr_in_range = ({1'b0, W0_addr} < DEPTH_EXT);
    assign rd_req      = run & R0_en;
    assign wr_req      = run & W0_en & wr_in_range;
    // Out-of-range reads are steered to a legal index; their data is zeroed below.
    assign rd_idx      = rd_in_range ? R0_addr : '0;

`ifdef MEM_1R1W_MASKED_FWD_EN
    logic             collide;
    logic [WIDTH-1:0] merged_word;

    assign collide = W0_en & (R0_addr == W0_addr);

    // Word the entry will hold after this edge's write: new lanes where masked in.
    for (genvar gi = 0; gi < MASK_W; gi++) begin : g_merge
        assign merged_word[gi*MASK_GRAN +: MASK_GRAN] =
            W0_mask[gi] ? W0_data[gi*MASK_GRAN +: MASK_GRAN]
                        : mem_q[rd_idx][gi*MASK_GRAN +: MASK_GRAN];
    end

    assign rd_word = !rd_in_range ? '0 : (collide ? merged_word : mem_q[rd_idx]);
`else
    assign rd_word = rd_in_range ? mem_q[rd_idx] : '0;
`endif

    // State and clear-counter registers; reset restarts the sweep at entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: step through every entry once, then stay in RUN until reset.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_INIT: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Array update: the sweep zeroes one entry per edge, RUN applies masked writes.
    // While reset is held the sweep sits at entry 0, so rewriting it with zero is harmless.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_req) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (W0_mask[i]) begin
                    mem_q[W0_addr][i*MASK_GRAN +: MASK_GRAN] <= W0_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // First read stage: capture the read word; data only moves with a request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q[0] <= 1'b0;
            dat_q[0] <= '0;
        end else begin
            vld_q[0] <= rd_req;
            if (rd_req) begin
                dat_q[0] <= rd_word;
            end
        end
    end

    // Extra latency stages: free-running shift; data advances only behind a valid,
    // so the last stage holds the most recent result while idle.
    for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q[gi] <= 1'b0;
                dat_q[gi] <= '0;
            end else begin
                vld_q[gi] <= vld_q[gi-1];
                if (vld_q[gi-1]) begin
                    dat_q[gi] <= dat_q[gi-1];
                end
            end
        end
    end

    assign R0_valid = vld_q[READ_LATENCY-1];
    assign R0_data  = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_1r1w_masked_param.sv
// Testbench for mem_1r1w_masked_param: random and directed traffic, reference
// model is a plain array plus an edge counter; expected read results go into a
// queue that a negedge monitor drains against R0_valid/R0_data.
module tb_mem_1r1w_masked_param;

    localparam int DEPTH = 48;
    localparam int WIDTH = 64;
    localparam int MG    = 8;
    localparam int RL    = 3;
    localparam int AW    = $clog2(DEPTH);
    localparam int MW    = WIDTH / MG;

    logic             clk;
    logic             rst_n;
    logic [AW-1:0]    R0_addr;
    logic             R0_en;
    logic [WIDTH-1:0] R0_data;
    logic             R0_valid;
    logic [AW-1:0]    W0_addr;
    logic             W0_en;
    logic [WIDTH-1:0] W0_data;
    logic [MW-1:0]    W0_mask;
    logic             init_done;

    mem_1r1w_masked_param #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(MG), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data), .R0_valid(R0_valid),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
        .init_done(init_done)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] model_mem [DEPTH];
    logic [WIDTH-1:0] last_data;
    int               edges;
    int               cyc;
    int               checks;
    int               failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old_w,
                                                    input logic [WIDTH-1:0] new_w,
                                                    input logic [MW-1:0] m);
        logic [WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < MW; i++)
            if (m[i]) r[i*MG +: MG] = new_w[i*MG +: MG];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] exp_read(input int ra, input logic wen, input int wa,
                                                  input logic [WIDTH-1:0] wd, input logic [MW-1:0] wm);
        if (ra >= DEPTH) return '0;
`ifdef MEM_1R1W_MASKED_FWD_EN
        if (wen && wa == ra) return lane_merge(model_mem[ra], wd, wm);
`endif
        return model_mem[ra];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // One clock: drive, wait for the edge, then update the model for that edge.
    task automatic tick(input logic ren, input logic [AW-1:0] ra, input logic wen,
                        input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd, input logic [MW-1:0] wm);
        exp_t e;
        R0_en = ren; R0_addr = ra; W0_en = wen; W0_addr = wa; W0_data = wd; W0_mask = wm;
        @(posedge clk);
        #1;
        if (rst_n) begin
            edges++;
            if (edges > DEPTH) begin
                if (ren) begin
                    e.data = exp_read(int'(ra), wen, int'(wa), wd, wm);
                    e.due  = cyc + RL - 1;
                    exp_q.push_back(e);
                end
                if (wen && int'(wa) < DEPTH)
                    model_mem[wa] = lane_merge(model_mem[wa], wd, wm);
            end
        end
        R0_en = 1'b0; W0_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic rd(input int a);
        tick(1'b1, AW'(a), 1'b0, '0, '0, '0);
    endtask

    task automatic wr(input int a, input logic [WIDTH-1:0] d, input logic [MW-1:0] m);
        tick(1'b0, '0, 1'b1, AW'(a), d, m);
    endtask

    // Monitor: checks outputs against the scoreboard on every falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            checks++;
            if (R0_valid !== 1'b0 || R0_data !== '0 || init_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs: valid=%b data=%h init_done=%b required 0/0/0",
                         R0_valid, R0_data, init_done);
            end
        end else begin
            checks++;
            if (init_done !== (edges >= DEPTH)) begin
                failures++;
                $display("FAIL init_done: got %b required %b (edge %0d)", init_done, edges >= DEPTH, edges);
            end
            if (R0_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid: R0_valid=1 data=%h with no read outstanding", R0_data);
                end else begin
                    e = exp_q.pop_front();
                    if (R0_data !== e.data) begin
                        failures++;
                        $display("FAIL read_data: got %h required %h", R0_data, e.data);
                    end
                    checks++;
                    if (cyc != e.due) begin
                        failures++;
                        $display("FAIL read_latency: result at cycle %0d required cycle %0d", cyc, e.due);
                    end
                    last_data = e.data;
                end
            end else begin
                checks++;
                if (R0_valid !== 1'b0 || R0_data !== last_data) begin
                    failures++;
                    $display("FAIL hold: valid=%b data=%h required valid=0 data=%h", R0_valid, R0_data, last_data);
                end
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_result: due cycle %0d, now %0d, required %h",
                             exp_q[0].due, cyc, exp_q[0].data);
                    e = exp_q.pop_front();
                end
            end
        end
    end

    initial begin
        int               ra, wa;
        logic             ren, wen;
        logic [WIDTH-1:0] wd;
        logic [MW-1:0]    wm;

        checks = 0; failures = 0; edges = 0; cyc = 0;
        last_data = '0;
        model_clear();
        R0_en = 1'b0; R0_addr = '0; W0_en = 1'b0; W0_addr = '0; W0_data = '0; W0_mask = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;

        // Sweep with request pulses that must all be ignored.
        for (int i = 0; i < DEPTH; i++)
            tick(1'b1, AW'($urandom_range(0, DEPTH-1)), 1'b1, AW'($urandom_range(0, DEPTH-1)),
                 {$urandom, $urandom}, '1);
        for (int i = 0; i < DEPTH; i++) rd(i);
        idle(RL + 1);

        // Masked write.
        wr(5, 64'h1122334455667788, 8'hFF);
        wr(5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        rd(5);
        idle(RL + 1);

        // Back-to-back reads, then idle to watch the held data.
        wr(0, {$urandom, $urandom}, 8'hFF);
        wr(1, {$urandom, $urandom}, 8'hFF);
        wr(2, {$urandom, $urandom}, 8'hFF);
        rd(0); rd(1); rd(2);
        idle(RL + 3);

        // Collision, then a follow-up read of the same entry.
        wr(7, '0, 8'hFF);
        tick(1'b1, AW'(7), 1'b1, AW'(7), '1, 8'h03);
        rd(7);
        idle(RL + 1);

        // Out of range write and read, then scan the whole array.
        wr(50, 64'h1234, 8'hFF);
        rd(50);
        rd(63);
        for (int i = 0; i < DEPTH; i++) rd(i);
        idle(RL + 1);

        // Random traffic biased towards a few addresses to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            ra  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 63);
            wa  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 63);
            ren = ($urandom_range(0, 3) != 0);
            wen = ($urandom_range(0, 2) != 0);
            wd  = {$urandom, $urandom};
            wm  = MW'($urandom);
            tick(ren, AW'(ra), wen, AW'(wa), wd, wm);
        end
        idle(RL + 1);

        // Asynchronous reset with two reads in flight.
        wr(5, 64'hDEADBEEF01234567, 8'hFF);
        rd(5);
        idle(RL + 1);
        rd(5); rd(6);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (R0_valid !== 1'b0 || R0_data !== '0 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: valid=%b data=%h init_done=%b required 0/0/0",
                     R0_valid, R0_data, init_done);
        end
        exp_q.delete();
        last_data = '0;
        edges = 0;
        model_clear();
        idle(2);
        rst_n = 1'b1;
        idle(DEPTH + 2);
        rd(5);
        rd(6);
        idle(RL + 2);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
